// File: rtl/mips_defs.sv
// Shared MIPS core definitions: hazard tags, primary opcodes and the canonical NOP word.
// Used by the fetch stage and the hazard unit so both agree on tag encodings.
package mips_defs;

  // Instruction class reported by the hazard unit for the word in ID
  localparam logic [1:0] TAG_NONE   = 2'd0;
  localparam logic [1:0] TAG_LOAD   = 2'd1;
  localparam logic [1:0] TAG_BRANCH = 2'd2;
  localparam logic [1:0] TAG_JUMP   = 2'd3;

  // Primary opcodes (ins[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // sll $0,$0,0
  localparam logic [31:0] NOP_INS = 32'h0000_0000;

  // What the fetch stage does with its state this cycle
  typedef enum logic [1:0] {
    ACT_ADV    = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_REDIR  = 2'd2,
    ACT_SQUASH = 2'd3
  } fetch_act_e;

endpackage

// File: rtl/pc_target.sv
// Redirect target generator for the instruction sitting in IF/ID.
// Branch targets are PC-relative off id_pc4; jump targets keep the id_pc4 region nibble.
module pc_target
  import mips_defs::*;
(
  input  logic [31:0] id_ins,
  input  logic [31:0] id_pc4,
  input  logic [1:0]  tag,
  output logic [31:0] target
);

  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] j_target;

  assign br_off    = {{14{id_ins[15]}}, id_ins[15:0], 2'b00};
  assign br_target = id_pc4 + $unsigned(br_off);
  assign j_target  = {id_pc4[31:28], id_ins[25:0], 2'b00};

  // Pick the target for the current tag; non-redirect tags fall back to the sequential path
  always_comb begin
    target = id_pc4;
    case (tag)
      TAG_BRANCH: target = br_target;
      TAG_JUMP:   target = j_target;
      default:    target = id_pc4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// Fetch stage and IF/ID register. Holds the PC, presents it to instruction memory,
// captures the returned word, and reacts to the hazard unit's stall/flush/tag controls.
// flush is active-low; a low flush while stalled is a load-use bubble and must not squash.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_en,
  input  logic             flush,
  input  logic [1:0]       tag,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic [31:0]      id_ins,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic [1:0]       flag,
  output logic [4:0]       rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  import mips_defs::*;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] redir_target;
  fetch_act_e  act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] one;
    one = '0;
    one[0] = 1'b1;
    return (&v) ? v : v + one;
  endfunction

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;

  pc_target u_pc_target (
    .id_ins (id_ins),
    .id_pc4 (id_pc4),
    .tag    (tag),
    .target (redir_target)
  );

  // Priority decode: stall beats any flush; a low flush redirects only for branch/jump tags
  always_comb begin
    act = ACT_ADV;
    if (!pc_en) begin
      act = ACT_STALL;
    end else if (!flush) begin
      act = (tag == TAG_BRANCH || tag == TAG_JUMP) ? ACT_REDIR : ACT_SQUASH;
    end
  end

  // PC, IF/ID register, EX-side tag/dest and event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      id_ins    <= NOP_INS;
      id_pc4    <= 32'd0;
      id_valid  <= 1'b0;
      flag      <= TAG_NONE;
      rd        <= 5'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (act)
        ACT_STALL: begin
          flag      <= TAG_NONE;
          stall_cnt <= sat_inc(stall_cnt);
        end
        ACT_REDIR: begin
          pc        <= redir_target;
          id_ins    <= NOP_INS;
          id_pc4    <= 32'd0;
          id_valid  <= 1'b0;
          flag      <= tag;
          rd        <= id_ins[20:16];
          flush_cnt <= sat_inc(flush_cnt);
        end
        ACT_SQUASH: begin
          pc        <= pc_plus4;
          id_ins    <= NOP_INS;
          id_pc4    <= 32'd0;
          id_valid  <= 1'b0;
          flag      <= tag;
          rd        <= id_ins[20:16];
        end
        default: begin
          pc        <= pc_plus4;
          id_ins    <= imem_data;
          id_pc4    <= pc_plus4;
          id_valid  <= 1'b1;
          flag      <= tag;
          rd        <= id_ins[20:16];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. Two instances share all inputs: the default one, and one
// relocated to 0x1000_0000 with 2-bit counters, so jump-region and saturation cases are
// visible without extra stimulus.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        flush;
  logic [1:0]  tag;
  logic [31:0] imem_data;

  logic [31:0] imem_addr, id_ins, id_pc4;
  logic        id_valid;
  logic [1:0]  flag;
  logic [4:0]  rd;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] imem_addr_b, id_ins_b, id_pc4_b;
  logic        id_valid_b;
  logic [1:0]  flag_b;
  logic [4:0]  rd_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INS(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .flush(flush), .tag(tag), .imem_data(imem_data),
    .imem_addr(imem_addr), .id_ins(id_ins), .id_pc4(id_pc4), .id_valid(id_valid),
    .flag(flag), .rd(rd), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_stage #(.RESET_PC(32'h1000_0000), .NOP_INS(32'h0000_0000), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .pc_en(pc_en), .flush(flush), .tag(tag), .imem_data(imem_data),
    .imem_addr(imem_addr_b), .id_ins(id_ins_b), .id_pc4(id_pc4_b), .id_valid(id_valid_b),
    .flag(flag_b), .rd(rd_b), .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pc_en = 1'b1; flush = 1'b1; tag = 2'd0; imem_data = 32'hDEAD_BEEF;

    // T1 reset
    tick(); tick();
    check_eq("t1_addr",   imem_addr, 32'h0);
    check_eq("t1_ins",    id_ins, 32'h0);
    check_eq("t1_pc4",    id_pc4, 32'h0);
    check_eq("t1_valid",  32'(id_valid), 32'h0);
    check_eq("t1_flag",   32'(flag), 32'h0);
    check_eq("t1_rd",     32'(rd), 32'h0);
    check_eq("t1_scnt",   32'(stall_cnt), 32'h0);
    check_eq("t1_fcnt",   32'(flush_cnt), 32'h0);
    check_eq("t1_addr_b", imem_addr_b, 32'h1000_0000);

    // T2 straight-line: A=addi, B=lw $5, C=add $6,$5,$5
    rst = 1'b0;
    imem_data = 32'h2001_0005; tick();
    check_eq("t2_insA",  id_ins, 32'h2001_0005);
    check_eq("t2_pc4A",  id_pc4, 32'd4);
    check_eq("t2_validA", 32'(id_valid), 32'h1);
    check_eq("t2_addrA", imem_addr, 32'd4);
    imem_data = 32'h8C05_0000; tick();
    check_eq("t2_insB",  id_ins, 32'h8C05_0000);
    check_eq("t2_pc4B",  id_pc4, 32'd8);
    check_eq("t2_rdB",   32'(rd), 32'd1);
    imem_data = 32'h00A5_3020; tag = 2'd1; tick();
    check_eq("t2_insC",  id_ins, 32'h00A5_3020);
    check_eq("t2_pc4C",  id_pc4, 32'd12);
    check_eq("t3_flag1", 32'(flag), 32'd1);
    check_eq("t3_rd5",   32'(rd), 32'd5);

    // T3 load-use stall: flush low must not squash
    pc_en = 1'b0; flush = 1'b0; tag = 2'd0; imem_data = 32'hBAD0_0001; tick();
    check_eq("t3_addr",  imem_addr, 32'd12);
    check_eq("t3_ins",   id_ins, 32'h00A5_3020);
    check_eq("t3_pc4",   id_pc4, 32'd12);
    check_eq("t3_valid", 32'(id_valid), 32'h1);
    check_eq("t3_flag0", 32'(flag), 32'h0);
    check_eq("t3_rdhold", 32'(rd), 32'd5);
    check_eq("t3_scnt",  32'(stall_cnt), 32'd1);
    check_eq("t3_fcnt",  32'(flush_cnt), 32'd0);

    // Advance to put beq (offset 3) in IF/ID with id_pc4=0x20
    pc_en = 1'b1; flush = 1'b1; tag = 2'd0; imem_data = 32'h0;
    for (int i = 0; i < 4; i++) tick();
    imem_data = 32'h1000_0003; tick();
    check_eq("t4_pre_ins", id_ins, 32'h1000_0003);
    check_eq("t4_pre_pc4", id_pc4, 32'h20);
    check_eq("t4_pre_pc4_b", id_pc4_b, 32'h1000_0020);

    // T4 taken branch
    flush = 1'b0; tag = 2'd2; imem_data = 32'hBAD0_BAD0; tick();
    check_eq("t4_addr",   imem_addr, 32'h2C);
    check_eq("t4_addr_b", imem_addr_b, 32'h1000_002C);
    check_eq("t4_ins",    id_ins, 32'h0);
    check_eq("t4_valid",  32'(id_valid), 32'h0);
    check_eq("t4_pc4",    id_pc4, 32'h0);
    check_eq("t4_flag",   32'(flag), 32'd2);
    check_eq("t4_fcnt",   32'(flush_cnt), 32'd1);

    // Backward branch to 0x0C (offset -9 from 0x30)
    flush = 1'b1; tag = 2'd0; imem_data = 32'h1000_FFF7; tick();
    check_eq("bk_pc4", id_pc4, 32'h30);
    flush = 1'b0; tag = 2'd2; tick();
    check_eq("bk_addr",   imem_addr, 32'h0C);
    check_eq("bk_addr_b", imem_addr_b, 32'h1000_000C);
    check_eq("bk_fcnt",   32'(flush_cnt), 32'd2);

    // T5 jump
    flush = 1'b1; tag = 2'd0; imem_data = 32'h0800_0040; tick();
    check_eq("t5_pre_pc4_b", id_pc4_b, 32'h1000_0010);
    flush = 1'b0; tag = 2'd3; imem_data = 32'hBAD0_0002; tick();
    check_eq("t5_addr",    imem_addr, 32'h100);
    check_eq("t5_addr_b",  imem_addr_b, 32'h1000_0100);
    check_eq("t5_flag",    32'(flag), 32'd3);
    check_eq("t5_fcnt",    32'(flush_cnt), 32'd3);
    check_eq("t5_fcnt_b",  32'(flush_cnt_b), 32'd3);

    // Squash with load tag: no redirect, sequential pc, flag=1
    flush = 1'b1; tag = 2'd0; imem_data = 32'h8C07_0000; tick();
    check_eq("sq_pre_pc4", id_pc4, 32'h104);
    flush = 1'b0; tag = 2'd1; imem_data = 32'hBAD0_0003; tick();
    check_eq("sq_addr",  imem_addr, 32'h108);
    check_eq("sq_valid", 32'(id_valid), 32'h0);
    check_eq("sq_ins",   id_ins, 32'h0);
    check_eq("sq_flag",  32'(flag), 32'd1);
    check_eq("sq_rd",    32'(rd), 32'd7);
    check_eq("sq_fcnt",  32'(flush_cnt), 32'd3);

    // T6 wrap: branch to 0xFFFF_FFFC (offset -68 from 0x10C), then advance to 0
    flush = 1'b1; tag = 2'd0; imem_data = 32'h1000_FFBC; tick();
    flush = 1'b0; tag = 2'd2; tick();
    check_eq("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    check_eq("t6_addr_b",   imem_addr_b, 32'h0FFF_FFFC);
    check_eq("t6_fcnt",     32'(flush_cnt), 32'd4);
    check_eq("t6_fcnt_sat", 32'(flush_cnt_b), 32'd3);
    flush = 1'b1; tag = 2'd0; imem_data = 32'h1000_0005; tick();
    check_eq("t6_wrap_addr", imem_addr, 32'h0);
    check_eq("t6_wrap_pc4",  id_pc4, 32'h0);
    check_eq("t6_wrap_addr_b", imem_addr_b, 32'h1000_0000);

    // Five stalls with a branch tag and flush low: stall wins, counters saturate on dut_b
    pc_en = 1'b0; flush = 1'b0; tag = 2'd2;
    for (int i = 0; i < 5; i++) tick();
    check_eq("t6_st_addr",  imem_addr, 32'h0);
    check_eq("t6_st_ins",   id_ins, 32'h1000_0005);
    check_eq("t6_st_flag",  32'(flag), 32'h0);
    check_eq("t6_scnt",     32'(stall_cnt), 32'd6);
    check_eq("t6_scnt_sat", 32'(stall_cnt_b), 32'd3);

    // Reset while stalled
    rst = 1'b1; tick();
    check_eq("t6_rst_addr",   imem_addr, 32'h0);
    check_eq("t6_rst_addr_b", imem_addr_b, 32'h1000_0000);
    check_eq("t6_rst_ins",    id_ins, 32'h0);
    check_eq("t6_rst_pc4",    id_pc4, 32'h0);
    check_eq("t6_rst_valid",  32'(id_valid), 32'h0);
    check_eq("t6_rst_flag",   32'(flag), 32'h0);
    check_eq("t6_rst_rd",     32'(rd), 32'h0);
    check_eq("t6_rst_scnt",   32'(stall_cnt), 32'h0);
    check_eq("t6_rst_fcnt",   32'(flush_cnt), 32'h0);
    check_eq("t6_rst_scnt_b", 32'(stall_cnt_b), 32'h0);

    rst = 1'b0; pc_en = 1'b1; flush = 1'b1; tag = 2'd0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
